// File: rtl/hapb_wr_arbiter_pkg.sv
// Shared types and default widths for the HAPB write-port arbiter.
package hapb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2
    } arb_state_e;

    localparam int ADDR_W     = 64;
    localparam int ID_W_DEF   = 12;
    localparam int DATA_W_DEF = 512;
    localparam int AWUSER_W   = 6;
    localparam int BUSER_W    = 4;

    // Index reached by stepping k places forward from base in a ring of n.
    function automatic int rr_offset(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/hapb_wr_arbiter_if.sv
// AXI4 write-channel bundle (AW/W/B); N parallel lanes, B response/ID shared.
interface hapb_wr_arbiter_if
    import hapb_arb_pkg::*;
#(
    parameter int N      = 1,
    parameter int ID_W   = ID_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [N-1:0]            awvalid;
    logic [N-1:0]            awready;
    logic [N*ADDR_W-1:0]     awaddr;
    logic [N*ID_W-1:0]       awid;
    logic [N*AWUSER_W-1:0]   awuser;
    logic [N-1:0]            wvalid;
    logic [N-1:0]            wready;
    logic [N-1:0]            wlast;
    logic [N*DATA_W-1:0]     wdata;
    logic [N*DATA_W/8-1:0]   wstrb;
    logic [N-1:0]            bvalid;
    logic [N-1:0]            bready;
    logic [1:0]              bresp;
    logic [ID_W-1:0]         bid;
    logic [BUSER_W-1:0]      buser;

    modport master (
        output awvalid, awaddr, awid, awuser, wvalid, wlast, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp, bid, buser
    );

    modport slave (
        input  awvalid, awaddr, awid, awuser, wvalid, wlast, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp, bid, buser
    );

endinterface

// File: rtl/hapb_rr_pick.sv
// Combinational round-robin selector: first requester after last_grant wins.
module hapb_rr_pick
    import hapb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int GW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      grant,
    output logic               any_req
);

    logic [GW-1:0] idx;

    // Scan farthest-first so the nearest requester after last_grant overwrites.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = GW'(rr_offset(int'(last_grant), k, NUM_REQ));
            if (req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hapb_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write port among NUM_REQ requesters,
// one transaction outstanding, with per-requester completion counters.
//
// state     | meaning
// IDLE      | no grant active; pick next requester from s.awvalid
// ADDR_DATA | AW and W of granted requester routed to master port
// RESP      | waiting for B; routed back to granted requester
module hapb_wr_arbiter
    import hapb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = ID_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    localparam int GW     = $clog2(NUM_REQ),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                   axi4_mm_clk,
    input  logic                   axi4_mm_rst_n,
    hapb_wr_arbiter_if.slave       s,
    hapb_wr_arbiter_if.master      m,
    output logic [GW-1:0]          grant_idx,
    output logic                   busy,
    output logic [NUM_REQ*32-1:0]  txn_cnt,
    output logic                   err_sticky
);

    arb_state_e                  state_q, state_d;
    logic [GW-1:0]               grant_q, grant_d;
    logic [GW-1:0]               last_grant_q, last_grant_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic [NUM_REQ-1:0][31:0]    txn_cnt_q, txn_cnt_d;
    logic                        err_q, err_d;

    logic [GW-1:0]               pick_grant;
    logic                        any_req;

    logic                        m_awvalid_o, m_wvalid_o, m_wlast_o, m_bready_o;
    logic [ADDR_W-1:0]           m_awaddr_o;
    logic [ID_W-1:0]             m_awid_o;
    logic [AWUSER_W-1:0]         m_awuser_o;
    logic [DATA_W-1:0]           m_wdata_o;
    logic [STRB_W-1:0]           m_wstrb_o;
    logic [NUM_REQ-1:0]          s_awready_o, s_wready_o, s_bvalid_o;
    logic [1:0]                  s_bresp_o;
    logic [ID_W-1:0]             s_bid_o;

    logic                        aw_hs, w_last_hs, b_hs;
    logic                        unused_buser;

    hapb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (s.awvalid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .any_req    (any_req)
    );

    assign aw_hs     = m_awvalid_o & m.awready[0];
    assign w_last_hs = m_wvalid_o & m.wready[0] & m_wlast_o;
    assign b_hs      = (state_q == RESP) & m.bvalid[0] & m_bready_o;

    always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
        if (!axi4_mm_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            txn_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            txn_cnt_q    <= txn_cnt_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        txn_cnt_d    = txn_cnt_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_grant;
                    state_d = ADDR_DATA;
                end
            end
            ADDR_DATA: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_last_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    txn_cnt_d[grant_q] = txn_cnt_q[grant_q] + 32'd1;
                    err_d              = err_q | m.bresp[1];
                    last_grant_d       = grant_q;
                    aw_done_d          = 1'b0;
                    w_done_d           = 1'b0;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Payloads follow the grant whenever a transaction is in flight; zero in IDLE.
    always_comb begin
        m_awvalid_o = 1'b0;
        m_wvalid_o  = 1'b0;
        m_wlast_o   = 1'b0;
        m_bready_o  = 1'b0;
        m_awaddr_o  = '0;
        m_awid_o    = '0;
        m_awuser_o  = '0;
        m_wdata_o   = '0;
        m_wstrb_o   = '0;
        s_awready_o = '0;
        s_wready_o  = '0;
        s_bvalid_o  = '0;
        s_bresp_o   = '0;
        s_bid_o     = '0;
        if (state_q != IDLE) begin
            m_awaddr_o = s.awaddr[int'(grant_q)*ADDR_W +: ADDR_W];
            m_awid_o   = s.awid[int'(grant_q)*ID_W +: ID_W];
            m_awuser_o = s.awuser[int'(grant_q)*AWUSER_W +: AWUSER_W];
            m_wdata_o  = s.wdata[int'(grant_q)*DATA_W +: DATA_W];
            m_wstrb_o  = s.wstrb[int'(grant_q)*STRB_W +: STRB_W];
            m_wlast_o  = s.wlast[grant_q];
        end
        if (state_q == ADDR_DATA) begin
            m_awvalid_o          = s.awvalid[grant_q] & ~aw_done_q;
            m_wvalid_o           = s.wvalid[grant_q] & ~w_done_q;
            s_awready_o[grant_q] = m.awready[0] & ~aw_done_q;
            s_wready_o[grant_q]  = m.wready[0] & ~w_done_q;
        end
        if (state_q == RESP) begin
            s_bvalid_o[grant_q] = m.bvalid[0];
            m_bready_o          = s.bready[grant_q];
            s_bresp_o           = m.bresp;
            s_bid_o             = m.bid;
        end
    end

    assign m.awvalid = m_awvalid_o;
    assign m.awaddr  = m_awaddr_o;
    assign m.awid    = m_awid_o;
    assign m.awuser  = m_awuser_o;
    assign m.wvalid  = m_wvalid_o;
    assign m.wlast   = m_wlast_o;
    assign m.wdata   = m_wdata_o;
    assign m.wstrb   = m_wstrb_o;
    assign m.bready  = m_bready_o;

    assign s.awready = s_awready_o;
    assign s.wready  = s_wready_o;
    assign s.bvalid  = s_bvalid_o;
    assign s.bresp   = s_bresp_o;
    assign s.bid     = s_bid_o;
    assign s.buser   = '0;

    assign unused_buser = ^m.buser;

    assign grant_idx  = grant_q;
    assign busy       = (state_q != IDLE);
    assign txn_cnt    = txn_cnt_q;
    assign err_sticky = err_q;

endmodule

// File: doc/hapb_wr_arbiter.md
# hapb_wr_arbiter

Shares the single AXI4-MM write port (AW/W/B) between `NUM_REQ` write requesters: the hot-address pusher that fills the HAPB in host memory, plus further host-write clients such as the migration-status writer. It sits between the requesters and the AXI write interface.

Arbitration is round-robin with one outstanding transaction. A grant is held from AW/W issue until the B response is returned to the granted requester. The block also keeps per-requester completion counters and a sticky error flag.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; requester 0 is the hot-address pusher.
- `ID_W`, 12: AXI ID width.
- `DATA_W`, 512: W data width; `wstrb` is `DATA_W/8`.

Ports:
- `axi4_mm_clk`  in  1  clock
- `axi4_mm_rst_n`  in  1  asynchronous active-low reset
- `s_awvalid`/`s_awready`  in/out  NUM_REQ  per-requester AW handshake
- `s_awaddr`  in  NUM_REQ*64  AW address, requester i at [i*64 +: 64]
- `s_awid`  in  NUM_REQ*ID_W  AW ID
- `s_awuser`  in  NUM_REQ*6  AW user
- `s_wvalid`/`s_wready`/`s_wlast`  in/out/in  NUM_REQ  per-requester W handshake and last-beat flag
- `s_wdata`  in  NUM_REQ*DATA_W  W data
- `s_wstrb`  in  NUM_REQ*DATA_W/8  W strobes
- `s_bvalid`/`s_bready`  out/in  NUM_REQ  per-requester B handshake
- `s_bresp`  out  2  B response, broadcast (qualified by `s_bvalid`)
- `s_bid`  out  ID_W  B ID, broadcast (qualified by `s_bvalid`)
- `m_aw*`, `m_w*`, `m_bvalid`/`m_bready`/`m_bresp`/`m_bid`: single master-side AXI write channel, same widths as one requester slice; `m_buser` in 4, ignored
- `grant_idx`  out  $clog2(NUM_REQ)  currently or last granted requester
- `busy`  out  1  high when the state is not IDLE
- `txn_cnt`  out  NUM_REQ*32  completed B handshakes per requester; wraps at 2^32
- `err_sticky`  out  1  set on any forwarded `m_bresp[1]==1`; cleared only by reset

## Operation
- FSM states and transitions:
  - **IDLE**:
    - Request vector is `s_awvalid`.
    - If any bit is set, pick the first set bit searching from `last_grant+1` modulo NUM_REQ.
    - Register the pick into `grant`, then go to ADDR_DATA.
  - **ADDR_DATA**:
    - `m_aw*` is driven from `s_aw*[grant]`; `m_awvalid = s_awvalid[grant] & ~aw_done`.
    - `m_w*` is driven from `s_w*[grant]`; `m_wvalid = s_wvalid[grant] & ~w_done`.
    - Ready signals route back to `s_awready[grant]` and `s_wready[grant]` only.
    - `aw_done` sets on the AW handshake.
    - `w_done` sets on a W handshake with `wlast`; multi-beat bursts are passed through.
    - When both are done (registered or in the current cycle), go to RESP.
    - AW and W may complete in either order or in the same cycle.
  - **RESP**:
    - `s_bvalid[grant] = m_bvalid` and `m_bready = s_bready[grant]`.
    - `s_bresp` and `s_bid` pass through from the master side.
    - On the B handshake:
      - `txn_cnt[grant]` increments.
      - `err_sticky` is ORed with `bresp[1]`.
      - `last_grant <= grant`; clear `aw_done` and `w_done`; go to IDLE.
- Signals of non-granted requesters are held at 0: `s_awready`, `s_wready`, `s_bvalid`.
- In IDLE, `m_awvalid`, `m_wvalid` and `m_bready` are 0. A stray `m_bvalid` in IDLE is ignored (not consumed).
- `m_awid` and `m_awuser` pass through unmodified; no ID retagging is needed with one transaction outstanding.
- A requester that drops `s_awvalid` or `s_wvalid` before its handshake is violating AXI; the arbiter holds the grant until completion regardless.

## Timing
- Reset values:
  - State IDLE, `grant=0`, `last_grant=NUM_REQ-1` (so requester 0 wins first), done flags 0, `txn_cnt=0`, `err_sticky=0`.
  - All valid and ready outputs are 0 and all `m_*` payloads are 0.
  - `busy=0`, `grant_idx=0`.
- Latency:
  - Arbitration takes 1 cycle: a request seen in IDLE at cycle N gives `m_awvalid`/`m_wvalid` at N+1.
  - Datapath is combinational pass-through with zero added latency.
  - After the B handshake at cycle M, the state is IDLE at M+1 and the next grant is visible at M+2.
  - Minimum 3 cycles per transaction.
- Fairness: round-robin, so any requester holding `s_awvalid` high is granted within NUM_REQ transactions.
- Reset mid-operation: on `axi4_mm_rst_n` falling, the FSM and all flags return to reset values asynchronously. Master-side valids drop the same cycle and the in-flight transaction is abandoned.

## Structure
- Package `hapb_arb_pkg`: state enum {IDLE, ADDR_DATA, RESP}, default widths (ID_W, DATA_W, AWUSER_W=6, BUSER_W=4).
- Sub-module `hapb_rr_pick`: combinational round-robin selector taking request vector and `last_grant`, returning `grant` index and `any_req`.
- Top level contains the FSM, the done flags, the muxes and the counters.

## Test plan
- Single requester 0: AW and W valid together, `awaddr=0x1000`, B returns OKAY -> one master write at 0x1000, `txn_cnt[0]=1`, 3-cycle turnaround.
- Both requesters valid continuously for 4 transactions -> grants alternate 0,1,0,1; counters end at 2 and 2.
- W handshake 3 cycles before AW with `m_awready` delayed, then a run with AW and W in the same cycle -> exactly one AW and one W each; RESP entered in both cases.
- 4-beat burst from requester 1, `wlast` on beat 4 -> RESP only after beat 4; requester 0 `s_wready` stays 0 throughout.
- `m_bresp=2'b10` -> `s_bresp=2'b10` to the granted requester and `err_sticky=1`, held across later OKAY responses.
- Reset asserted in ADDR_DATA -> `m_awvalid=0` the same cycle; after release requester 0 wins first.
